// File: rtl/dmi_dr_engine.sv
// dmi_dr_engine: DMI data register with a posted request queue, outstanding-response tracking and a sticky error.
module dmi_dr_engine #(
   parameter int AddrWidth  = 7,
   parameter int DataWidth  = 32,
   parameter int QueueDepth = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 capture_dr_i,
   input  logic                 shift_dr_i,
   input  logic                 update_dr_i,
   input  logic                 test_logic_reset_i,
   input  logic                 dmi_access_i,
   input  logic                 dmi_reset_i,
   input  logic                 dmi_hard_reset_i,
   input  logic                 tdi_i,
   output logic                 tdo_o,
   output logic [1:0]           error_o,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic [AddrWidth-1:0] req_addr_o,
   output logic [DataWidth-1:0] req_data_o,
   output logic [1:0]           req_op_o,
   input  logic                 resp_valid_i,
   output logic                 resp_ready_o,
   input  logic [DataWidth-1:0] resp_data_i,
   input  logic [1:0]           resp_code_i
);
   localparam int W  = AddrWidth + DataWidth + 2;
   localparam int CW = $clog2(QueueDepth + 1);
   localparam int PW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;

   logic [W-1:0]           dr_q;
   logic [W-1:0]           fifo_q [QueueDepth];
   logic [QueueDepth-1:0]  kind_q;
   logic [PW-1:0]          wp_q, rp_q, kwp_q, krp_q;
   logic [CW-1:0]          c_q, o_q;
   logic                   read_pending_q;
   logic [AddrWidth-1:0]   addr_q;
   logic [DataWidth-1:0]   data_q;
   logic [1:0]             error_q;
   logic                   cap, upd, rw, full, push, busy, issue, resp, fail;
   logic [1:0]             op, status;
   logic [W-1:0]           head;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(QueueDepth - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      cap    = capture_dr_i && dmi_access_i;
      upd    = update_dr_i && dmi_access_i && (error_q == 2'd0);
      op     = dr_q[1:0];
      rw     = (op == 2'd1) || (op == 2'd2);
      full   = (c_q == CW'(QueueDepth));
      push   = upd && rw && !read_pending_q && !full && !dmi_hard_reset_i;
      busy   = (upd && rw && (read_pending_q || full)) || (cap && (error_q == 2'd0) && read_pending_q);
      head   = fifo_q[rp_q];
      issue  = req_valid_o && req_ready_i;
      resp   = resp_valid_i && (o_q != '0);
      fail   = resp && (resp_code_i == 2'd2) && (error_q == 2'd0);
      status = (error_q != 2'd0) ? error_q : read_pending_q ? 2'd3 : 2'd0;
   end

   assign req_valid_o = (c_q != '0) && (o_q < CW'(QueueDepth));
   assign {req_addr_o, req_data_o, req_op_o} = head;
   assign resp_ready_o = 1'b1;
   assign tdo_o = dr_q[0];
   assign error_o = error_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dr_q           <= '0;
         for (int i = 0; i < QueueDepth; i++) fifo_q[i] <= '0;
         kind_q         <= '0;
         wp_q           <= '0;
         rp_q           <= '0;
         kwp_q          <= '0;
         krp_q          <= '0;
         c_q            <= '0;
         o_q            <= '0;
         read_pending_q <= 1'b0;
         addr_q         <= '0;
         data_q         <= '0;
         error_q        <= 2'd0;
      end else begin
         if (test_logic_reset_i) dr_q <= '0;
         else if (cap) dr_q <= {addr_q, data_q, status};
         else if (shift_dr_i && dmi_access_i) dr_q <= {tdi_i, dr_q[W-1:1]};
         if (push) begin
            fifo_q[wp_q] <= dr_q;
            wp_q         <= inc(wp_q);
            addr_q       <= dr_q[W-1 -: AddrWidth];
            if (op == 2'd1) read_pending_q <= 1'b1;
            else data_q <= dr_q[DataWidth+1:2];
         end
         if (issue) begin
            rp_q          <= inc(rp_q);
            kind_q[kwp_q] <= (head[1:0] == 2'd1);
            kwp_q         <= inc(kwp_q);
         end
         if (resp) begin
            krp_q <= inc(krp_q);
            if (kind_q[krp_q]) begin
               data_q         <= resp_data_i;
               read_pending_q <= 1'b0;
            end
         end
         // Hard reset drops queued work and marks every in-flight response as discard-only.
         if (dmi_hard_reset_i) begin
            wp_q           <= '0;
            rp_q           <= '0;
            kind_q         <= '0;
            read_pending_q <= 1'b0;
         end
         c_q     <= dmi_hard_reset_i ? '0 : c_q + CW'(push) - CW'(issue);
         o_q     <= o_q + CW'(issue) - CW'(resp);
         error_q <= (dmi_reset_i || dmi_hard_reset_i) ? 2'd0 : busy ? 2'd3 : fail ? 2'd2 : error_q;
      end
   end
endmodule

// File: tb/tb_dmi_dr_engine.sv
// tb_dmi_dr_engine: directed scoreboard bench; issued requests are checked by a monitor against queued expectations.
module tb_dmi_dr_engine;
   localparam int AW = 7, DW = 32, QD = 4, W = AW + DW + 2;

   logic clk_i = 0, rst_ni = 0;
   logic capture_dr_i = 0, shift_dr_i = 0, update_dr_i = 0, test_logic_reset_i = 0;
   logic dmi_access_i = 1, dmi_reset_i = 0, dmi_hard_reset_i = 0, tdi_i = 0;
   logic tdo_o, req_valid_o, req_ready_i = 0, resp_valid_i = 0, resp_ready_o;
   logic [1:0] error_o, req_op_o, resp_code_i = 0;
   logic [AW-1:0] req_addr_o;
   logic [DW-1:0] req_data_o, resp_data_i = 0;

   int n_vec = 0, n_err = 0;
   logic [W-1:0] sb [$];
   logic [W-1:0] mon_exp;

   dmi_dr_engine #(.AddrWidth(AW), .DataWidth(DW), .QueueDepth(QD)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .capture_dr_i(capture_dr_i), .shift_dr_i(shift_dr_i),
      .update_dr_i(update_dr_i), .test_logic_reset_i(test_logic_reset_i), .dmi_access_i(dmi_access_i),
      .dmi_reset_i(dmi_reset_i), .dmi_hard_reset_i(dmi_hard_reset_i), .tdi_i(tdi_i), .tdo_o(tdo_o),
      .error_o(error_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
      .req_data_o(req_data_o), .req_op_o(req_op_o), .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
      .resp_data_i(resp_data_i), .resp_code_i(resp_code_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [W-1:0] mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] o);
      return {a, d, o};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted request must match the oldest expectation.
   always @(negedge clk_i) begin
      if (rst_ni && req_valid_o && req_ready_i) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_req: got %h expected none", {req_addr_o, req_data_o, req_op_o});
         end else begin
            mon_exp = sb.pop_front();
            chk("req", 64'({req_addr_o, req_data_o, req_op_o}), 64'(mon_exp));
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic step(input string name, input logic [W-1:0] din, input bit do_upd, input logic [W-1:0] exp);
      logic [W-1:0] dout;
      capture_dr_i = 1;
      tick();
      capture_dr_i = 0;
      for (int i = 0; i < W; i++) begin
         tdi_i = din[i];
         shift_dr_i = 1;
         dout[i] = tdo_o;
         tick();
      end
      shift_dr_i = 0;
      if (do_upd) begin
         update_dr_i = 1;
         tick();
         update_dr_i = 0;
      end
      chk(name, 64'(dout), 64'(exp));
   endtask

   task automatic respond(input logic [DW-1:0] d, input logic [1:0] code);
      resp_valid_i = 1;
      resp_data_i = d;
      resp_code_i = code;
      tick();
      resp_valid_i = 0;
      resp_code_i = 0;
   endtask

   task automatic pulse_dmi_reset();
      dmi_reset_i = 1;
      tick();
      dmi_reset_i = 0;
   endtask

   task automatic pulse_hard_reset();
      dmi_hard_reset_i = 1;
      tick();
      dmi_hard_reset_i = 0;
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         tick();
         k++;
      end
      chk(name, 64'(sb.size()), 64'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle(3);
      chk("rst_valid", 64'(req_valid_o), 64'd0);
      chk("rst_resp_ready", 64'(resp_ready_o), 64'd1);
      chk("rst_error", 64'(error_o), 64'd0);
      chk("rst_tdo", 64'(tdo_o), 64'd0);
      rst_ni = 1;
      tick();
      step("cap_zero", '0, 0, mk(0, 0, 0));
      chk("err_after_reset", 64'(error_o), 64'd0);
      chk("valid_after_reset", 64'(req_valid_o), 64'd0);

      // Posted writes held back, then released in order.
      step("w1", mk(7'h10, 32'h11, 2), 1, mk(0, 0, 0));
      sb.push_back(mk(7'h10, 32'h11, 2));
      step("w2", mk(7'h10, 32'h22, 2), 1, mk(7'h10, 32'h11, 0));
      sb.push_back(mk(7'h10, 32'h22, 2));
      step("w3", mk(7'h10, 32'h33, 2), 1, mk(7'h10, 32'h22, 0));
      sb.push_back(mk(7'h10, 32'h33, 2));
      chk("w_err", 64'(error_o), 64'd0);
      chk("w_valid", 64'(req_valid_o), 64'd1);
      req_ready_i = 1;
      drain("drain_w");
      repeat (3) respond(32'h0, 2'd0);

      // Read, early capture goes Busy and blocks the next update.
      step("rd", mk(7'h04, 32'h0, 1), 1, mk(7'h10, 32'h33, 0));
      sb.push_back(mk(7'h04, 32'h0, 1));
      drain("drain_rd");
      step("cap_busy", mk(7'h05, 32'hAA, 2), 1, mk(7'h04, 32'h33, 3));
      chk("busy_err", 64'(error_o), 64'd3);
      idle(5);
      respond(32'hDEADBEEF, 2'd0);
      chk("busy_sticky", 64'(error_o), 64'd3);
      pulse_dmi_reset();
      chk("busy_clear", 64'(error_o), 64'd0);
      step("cap_rdata", '0, 0, mk(7'h04, 32'hDEADBEEF, 0));

      // Queue full: fifth write rejected.
      req_ready_i = 0;
      step("f1", mk(7'h20, 32'd1, 2), 1, mk(7'h04, 32'hDEADBEEF, 0));
      for (int i = 2; i <= 5; i++)
         step("fn", mk(7'h20, 32'(i), 2), 1, mk(7'h20, 32'(i - 1), 0));
      for (int i = 1; i <= 4; i++) sb.push_back(mk(7'h20, 32'(i), 2));
      chk("full_err", 64'(error_o), 64'd3);
      pulse_dmi_reset();
      chk("full_clear", 64'(error_o), 64'd0);
      req_ready_i = 1;
      drain("drain_full");
      repeat (4) respond(32'h0, 2'd0);
      step("cap_full", '0, 0, mk(7'h20, 32'd4, 0));

      // Failed response sets OPFailed; updates are ignored until cleared.
      step("wf", mk(7'h30, 32'h77, 2), 1, mk(7'h20, 32'd4, 0));
      sb.push_back(mk(7'h30, 32'h77, 2));
      drain("drain_wf");
      respond(32'h0, 2'd2);
      chk("opfail_err", 64'(error_o), 64'd2);
      step("wf_ign", mk(7'h31, 32'h88, 2), 1, mk(7'h30, 32'h77, 2));
      idle(5);
      pulse_dmi_reset();
      chk("opfail_clear", 64'(error_o), 64'd0);
      step("wf_ok", mk(7'h31, 32'h99, 2), 1, mk(7'h30, 32'h77, 0));
      sb.push_back(mk(7'h31, 32'h99, 2));
      drain("drain_wf_ok");
      respond(32'h0, 2'd0);

      // Hard reset with a write and a read in flight.
      step("hw", mk(7'h40, 32'hAB, 2), 1, mk(7'h31, 32'h99, 0));
      sb.push_back(mk(7'h40, 32'hAB, 2));
      drain("drain_hw");
      step("hr", mk(7'h41, 32'h0, 1), 1, mk(7'h40, 32'hAB, 0));
      sb.push_back(mk(7'h41, 32'h0, 1));
      drain("drain_hr");
      req_ready_i = 0;
      step("hbusy", mk(7'h42, 32'hCC, 2), 1, mk(7'h41, 32'hAB, 3));
      chk("hbusy_err", 64'(error_o), 64'd3);
      pulse_hard_reset();
      chk("hard_err", 64'(error_o), 64'd0);
      step("cap_hard", '0, 0, mk(7'h41, 32'hAB, 0));
      respond(32'h12345678, 2'd0);
      respond(32'hCAFEF00D, 2'd0);
      step("cap_absorb", '0, 0, mk(7'h41, 32'hAB, 0));

      // Hard reset flushes an unissued entry.
      step("hq", mk(7'h50, 32'h1, 2), 1, mk(7'h41, 32'hAB, 0));
      pulse_hard_reset();
      req_ready_i = 1;
      idle(10);
      chk("flush_valid", 64'(req_valid_o), 64'd0);

      // Four back-to-back writes only all issue if the outstanding count drained to zero.
      step("o1", mk(7'h60, 32'd1, 2), 1, mk(7'h50, 32'h1, 0));
      sb.push_back(mk(7'h60, 32'd1, 2));
      for (int i = 2; i <= 4; i++) begin
         step("on", mk(7'h60, 32'(i), 2), 1, mk(7'h60, 32'(i - 1), 0));
         sb.push_back(mk(7'h60, 32'(i), 2));
      end
      drain("drain_o");
      repeat (4) respond(32'h0, 2'd0);
      respond(32'hFFFF, 2'd2);
      chk("stray_resp_err", 64'(error_o), 64'd0);
      idle(3);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
